// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver/transmitter state encoding
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 120;
   localparam int DATA_BITS            = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic I_clk,
   input  logic I_reset,
   input  logic I_d,
   output logic O_q
);

   logic meta;

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         meta <= RESET_VAL;
         O_q  <= RESET_VAL;
      end else begin
         meta <= I_d;
         O_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with valid/ack holding register
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                 I_clk,
   input  logic                 I_reset,
   input  logic                 I_data,
   input  logic                 I_ack,
   output logic [DATA_BITS-1:0] O_data,
   output logic                 O_valid,
   output logic                 O_frame_err,
   output logic                 O_overrun
);

   localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0] FULL_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_t          state;
   logic [7:0]           clk_count;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 stop_sample;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .I_clk   (I_clk),
      .I_reset (I_reset),
      .I_d     (I_data),
      .O_q     (rx_s)
   );

   assign stop_sample = (state == ST_STOP) && (clk_count == FULL_LAST);

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         state       <= ST_IDLE;
         clk_count   <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         O_data      <= '0;
         O_valid     <= 1'b0;
         O_frame_err <= 1'b0;
         O_overrun   <= 1'b0;
      end else begin
         // Holding register: a delivery wins over a plain ack in the same cycle
         if (stop_sample) begin
            if (!O_valid || I_ack) begin
               O_data      <= shift;
               O_frame_err <= ~rx_s;
               O_valid     <= 1'b1;
               if (I_ack) O_overrun <= 1'b0;
            end else begin
               O_overrun <= 1'b1;
            end
         end else if (I_ack && O_valid) begin
            O_valid   <= 1'b0;
            O_overrun <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               clk_count <= '0;
               bit_idx   <= '0;
               if (!rx_s) state <= ST_START;
            end
            ST_START: begin
               if (clk_count == HALF_LAST) begin
                  clk_count <= '0;
                  state     <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  clk_count <= clk_count + 8'd1;
               end
            end
            ST_DATA: begin
               if (clk_count == FULL_LAST) begin
                  clk_count <= '0;
                  shift     <= {rx_s, shift[DATA_BITS-1:1]};
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == LAST_BIT) state <= ST_STOP;
               end else begin
                  clk_count <= clk_count + 8'd1;
               end
            end
            ST_STOP: begin
               if (stop_sample) begin
                  clk_count <= '0;
                  // A low stop bit parks in BREAK so a held-low line cannot retrigger
                  state     <= rx_s ? ST_IDLE : ST_BREAK;
               end else begin
                  clk_count <= clk_count + 8'd1;
               end
            end
            ST_BREAK: begin
               if (rx_s) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
